// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU select, ALUOp, funct and opcode constants for the ALU and its decoders.
package mips_pkg;
    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_NOR = 4'b1100;
    localparam logic [3:0] SEL_BAD = 4'b1111;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
endpackage

// File: rtl/alu_control.sv
// alu_control: combinational ALUOp/funct/opcode to ALU select decoder with illegal-combination flag.
module alu_control
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    input  logic [5:0] opcode,
    output logic [3:0] sel,
    output logic       illegal
);
    logic [3:0] r_sel;
    logic [3:0] i_sel;

    always_comb begin
        r_sel = SEL_BAD;
        case (funct)
            FUNCT_ADD: r_sel = SEL_ADD;
            FUNCT_SUB: r_sel = SEL_SUB;
            FUNCT_AND: r_sel = SEL_AND;
            FUNCT_OR:  r_sel = SEL_OR;
            FUNCT_SLT: r_sel = SEL_SLT;
            FUNCT_NOR: r_sel = SEL_NOR;
            default:   r_sel = SEL_BAD;
        endcase
        i_sel = SEL_BAD;
        case (opcode)
            OP_ADDI: i_sel = SEL_ADD;
            OP_ANDI: i_sel = SEL_AND;
            OP_ORI:  i_sel = SEL_OR;
            OP_SLTI: i_sel = SEL_SLT;
            default: i_sel = SEL_BAD;
        endcase
    end

    assign sel = (alu_op == ALUOP_MEM)   ? SEL_ADD :
                 (alu_op == ALUOP_BEQ)   ? SEL_SUB :
                 (alu_op == ALUOP_RTYPE) ? r_sel : i_sel;
    assign illegal = (sel == SEL_BAD);
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU select decode, stall/flush and EX/MEM, MEM/WB forwarding.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [5:0]            id_opcode,
    input  logic [5:0]            id_funct,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_dst,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_dst,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic [DATA_W-1:0]     ex_op1,
    output logic [DATA_W-1:0]     ex_op2,
    output logic [3:0]            ex_sel,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_dst,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_illegal
);
    logic [3:0] dec_sel;
    logic       dec_illegal;

    alu_control u_alu_control (
        .alu_op  (id_alu_op),
        .funct   (id_funct),
        .opcode  (id_opcode),
        .sel     (dec_sel),
        .illegal (dec_illegal)
    );

    logic                  bubble, load;
    logic [DATA_W-1:0]     rs_data_d, rt_data_d, imm_d, rs_data_q, rt_data_q, imm_q;
    logic [REG_ADDR_W-1:0] rs_d, rt_d, dst_d, rs_q, rt_q, dst_q;
    logic [3:0]            sel_d, sel_q;
    logic                  valid_d, reg_write_d, mem_read_d, mem_write_d, mem_to_reg_d, illegal_d, alu_src_d;
    logic                  valid_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, illegal_q, alu_src_q;

    // rst and flush both force a bubble; either one also overrides a stall
    assign bubble = rst | flush | ~id_valid;
    assign load   = rst | flush | ~stall;

    always_comb begin
        rs_data_d    = bubble ? '0 : id_rs_data;
        rt_data_d    = bubble ? '0 : id_rt_data;
        imm_d        = bubble ? '0 : id_imm;
        rs_d         = bubble ? '0 : id_rs;
        rt_d         = bubble ? '0 : id_rt;
        dst_d        = bubble ? '0 : (id_reg_dst ? id_rd : id_rt);
        sel_d        = bubble ? SEL_ADD : dec_sel;
        valid_d      = ~bubble;
        illegal_d    = ~bubble & dec_illegal;
        reg_write_d  = ~bubble & ~dec_illegal & id_reg_write;
        mem_read_d   = ~bubble & ~dec_illegal & id_mem_read;
        mem_write_d  = ~bubble & ~dec_illegal & id_mem_write;
        mem_to_reg_d = ~bubble & id_mem_to_reg;
        alu_src_d    = ~bubble & id_alu_src;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            dst_q        <= dst_d;
            sel_q        <= sel_d;
            valid_q      <= valid_d;
            illegal_q    <= illegal_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_src_q    <= alu_src_d;
        end
    end

    logic [DATA_W-1:0] fwd_rs, fwd_rt;

    // EX/MEM is the younger producer, so it is checked first
    assign fwd_rs = (exmem_reg_write && exmem_dst == rs_q && rs_q != '0) ? exmem_result :
                    (memwb_reg_write && memwb_dst == rs_q && rs_q != '0) ? memwb_result : rs_data_q;
    assign fwd_rt = (exmem_reg_write && exmem_dst == rt_q && rt_q != '0) ? exmem_result :
                    (memwb_reg_write && memwb_dst == rt_q && rt_q != '0) ? memwb_result : rt_data_q;

    assign ex_op1        = fwd_rs;
    assign ex_op2        = alu_src_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_sel        = sel_q;
    assign ex_dst        = dst_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;
    assign ex_illegal    = illegal_q;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage that sits directly upstream of the 32-bit ALU. It registers decoded operands and control signals. It translates ALUOp/funct/opcode into the ALU's 4-bit select. It also resolves EX/MEM and MEM/WB data hazards, so the ALU receives final op1/op2/sel values. It supports pipeline stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
DATA_W, 32, datapath/operand width
REG_ADDR_W, 5, register-file address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
id_valid  in  1  decode slot holds a real instruction
stall  in  1  hold all ID/EX registers
flush  in  1  load a bubble
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_rs, id_rt, id_rd  in  REG_ADDR_W  source/destination register numbers
id_opcode, id_funct  in  6  instruction opcode / funct fields
id_alu_op  in  2  main-decoder ALUOp
id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  main-decoder controls
exmem_reg_write  in  1;  exmem_dst  in  REG_ADDR_W;  exmem_result  in  DATA_W  EX/MEM forward source
memwb_reg_write  in  1;  memwb_dst  in  REG_ADDR_W;  memwb_result  in  DATA_W  MEM/WB forward source
ex_op1, ex_op2  out  DATA_W  to ALU op1/op2
ex_sel  out  4  to ALU sel
ex_store_data  out  DATA_W  forwarded rt value for stores
ex_dst  out  REG_ADDR_W  write-back destination
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal  out  1  registered controls

Behaviour:
- Single clock, clk. rst is synchronous and active-high.
- Update priority each rising edge: rst > flush > stall > load. Flush overrides a simultaneous stall.
- rst or flush loads a bubble:
  - all data/address registers = 0
  - ex_sel = 4'b0010
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg and ex_illegal = 0
  - a rst asserted mid-stall also produces the bubble
- stall: every register holds. Forwarding muxes stay live, so ex_op1/op2 track new EX/MEM and MEM/WB values while held.
- load: capture all id_* fields one cycle later (latency 1).
  - id_valid=0 loads a bubble.
  - ex_dst = id_reg_dst ? id_rd : id_rt.
- Select decode is combinational on the ID side and registered into ex_sel:
  - ALUOp 00 -> 0010 ADD (lw/sw)
  - ALUOp 01 -> 0110 SUB (beq)
  - ALUOp 10, by funct:
    - 100000 -> 0010
    - 100010 -> 0110
    - 100100 -> 0000
    - 100101 -> 0001
    - 101010 -> 0111
    - 100111 -> 1100
  - ALUOp 11, by opcode:
    - 001000 -> 0010
    - 001100 -> 0000
    - 001101 -> 0001
    - 001010 -> 0111
  - Any other combination -> 1111. In that case ex_illegal=1 and ex_reg_write, ex_mem_write and ex_mem_read are forced to 0. ex_valid stays 1.
- Forwarding is combinational on the registered rs/rt numbers, evaluated per operand:
  - If exmem_reg_write and exmem_dst == reg and reg != 0, use exmem_result.
  - Else if memwb_reg_write and memwb_dst == reg and reg != 0, use memwb_result.
  - Otherwise use the registered register-file data.
  - EX/MEM always wins over MEM/WB.
  - Register 0 is never forwarded.
- ex_op1 = fwd_rs.
- ex_op2 = alu_src ? registered imm : fwd_rt.
- ex_store_data = fwd_rt, regardless of alu_src.
- No arithmetic in this block. Widths pass through unchanged.

Decomposition:
- Shared package (mips_pkg) holds:
  - ALU select constants: SEL_AND, SEL_OR, SEL_ADD, SEL_SUB, SEL_SLT, SEL_NOR, SEL_BAD
  - ALUOp constants
  - funct and opcode constants
  - the ALU shares this package
- One sub-module is natural: alu_control, the combinational ALUOp/funct/opcode -> sel + illegal decoder, reusable by the single-cycle datapath.
- Forwarding muxes and pipeline registers stay in id_ex_stage.

Test Plan:
- Reset: hold rst 2 cycles with id_valid=1 and arbitrary inputs -> ex_valid=0, ex_reg_write=0, ex_sel=0010, ex_op1=ex_op2=0.
- R-type decode: ALUOp=10, funct=101010, rs_data=5, rt_data=9, no forwarding -> next cycle ex_sel=0111, op1=5, op2=9. Repeat for 100111 -> ex_sel=1100.
- Forward priority: registered rs=3. exmem_dst=3, exmem_result=0xAAAA0000; memwb_dst=3, memwb_result=0x5555 -> op1=0xAAAA0000. Drop exmem_reg_write -> op1=0x5555. Same test with rs=0 -> no forwarding.
- Immediate/store: ALUOp=00, alu_src=1, imm=0xFFFFFFFC, rt forwarded from MEM/WB value 0x1234 -> op2=0xFFFFFFFC, ex_store_data=0x1234, ex_sel=0010.
- Stall then flush: load addi (opcode 001000), then stall 3 cycles while the id_* fields change -> outputs unchanged. Assert stall+flush together -> bubble next cycle.
- Illegal: ALUOp=10, funct=000000, id_reg_write=1 -> ex_sel=1111, ex_illegal=1, ex_reg_write=0, ex_valid=1.
